init_loader: RTL and testbench

Sequencer that fills a bank of `NUM_REGS` enable-registers with initial values taken from a valid/ready word stream. It sits directly upstream of the per-register init registers. It drives their shared `val` bus and a one-hot `en` vector, so each downstream register captures exactly one word. It also reports completion to the top-level controller.

---
 rtl/init_loader_pkg.sv | 13 +
 rtl/init_loader_idx_onehot.sv | 18 +
 rtl/init_loader.sv | 165 ++++++++++++++++
 tb/tb_init_loader.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/init_loader_pkg.sv
// init_loader_pkg: shared state encoding for the init_loader sequencer.
package init_loader_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/init_loader_idx_onehot.sv
// idx_onehot: combinational index to one-hot decoder that feeds the en register.
module idx_onehot #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic [IDX_W-1:0]    idx,
    output logic [NUM_REGS-1:0] onehot
);

    // Decode idx; out-of-range indices produce all zeros.
    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            onehot[i] = (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/init_loader.sv
// init_loader: fills NUM_REGS downstream init registers from a valid/ready
// word stream via a shared val bus and a one-hot en strobe.
// Optional feature: define INIT_LOADER_CHECKSUM_EN to consume a trailing XOR
// checksum word and report a mismatch on err.
module init_loader
    import init_loader_pkg::*;
#(
    parameter int unsigned SIZE     = 3,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SIZE-1:0]     in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [SIZE-1:0]     val,
    output logic [NUM_REGS-1:0] en,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_t                state_q;
    state_t                state_d;
    logic [IDX_W-1:0]      idx_q;
    logic [NUM_REGS-1:0]   idx_dec;
    logic                  accept;
    logic                  last;

    assign accept = in_valid & in_ready;
    assign last   = (idx_q == IDX_W'(NUM_REGS - 1));

    idx_onehot #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_dec (
        .idx    (idx_q),
        .onehot (idx_dec)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept && last) begin
`ifdef INIT_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end
            end
            CHECK: begin
`ifdef INIT_LOADER_CHECKSUM_EN
                if (accept) begin
                    state_d = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state only.
    always_comb begin
        in_ready = 1'b0;
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        case (state_q)
            LOAD:    in_ready = 1'b1;
`ifdef INIT_LOADER_CHECKSUM_EN
            CHECK:   in_ready = 1'b1;
`endif
            default: in_ready = 1'b0;
        endcase
    end

    // Load datapath: index counter, registered word and one-hot strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            val   <= '0;
            en    <= '0;
        end else begin
            en <= '0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        val   <= in_data;
                        en    <= idx_dec;
                        idx_q <= last ? '0 : idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef INIT_LOADER_CHECKSUM_EN
    logic [SIZE-1:0] csum_q;
    logic            err_q;

    // Running XOR over loaded words; compared against the trailing word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        csum_q <= '0;
                        err_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        csum_q <= csum_q ^ in_data;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        err_q <= (in_data != csum_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_init_loader.sv
// tb_init_loader: directed self-checking bench for init_loader with a model of
// the downstream register bank. Honours INIT_LOADER_CHECKSUM_EN.
module tb_init_loader;

    localparam int SIZE = 3;
    localparam int NR   = 4;
`ifdef INIT_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [SIZE-1:0] in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [SIZE-1:0] val;
    logic [NR-1:0]   en;
    logic            busy;
    logic            done;
    logic            err;

    int checks   = 0;
    int failures = 0;

    logic [SIZE-1:0] dreg [NR];
    int              wr_cnt [NR];
    int              done_cnt = 0;

    always #5 clk = ~clk;

    init_loader #(
        .SIZE     (SIZE),
        .NUM_REGS (NR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .val      (val),
        .en       (en),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Downstream register bank sharing val, one en bit each.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                dreg[i]   <= '0;
                wr_cnt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (en[i]) begin
                    dreg[i]   <= val;
                    wr_cnt[i] <= wr_cnt[i] + 1;
                end
            end
        end
    end

    // Continuous invariants: en at most one-hot, and never set while idle.
    always @(negedge clk) begin
        if (done) done_cnt = done_cnt + 1;
        checks = checks + 1;
        if ($countones(en) > 1 || (!busy && en !== '0)) begin
            failures = failures + 1;
            $display("FAIL en_invariant: en=%b busy=%b", en, busy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        checks++;
        if (en !== '0 || val !== '0 || busy !== 1'b0 || in_ready !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: en=%b val=%0d busy=%b rdy=%b done=%b err=%b (want all 0)",
                     en, val, busy, in_ready, done, err);
        end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: busy=%b rdy=%b (want 0 0)", busy, in_ready);
        end
    endtask

    task automatic test_basic();
        logic [SIZE-1:0] w [NR];
        logic [SIZE-1:0] cs;
        int              dbase;
        w = '{3'd5, 3'd2, 3'd7, 3'd1};
        cs = '0;
        dbase = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || en !== '0) begin
            failures++;
            $display("FAIL basic_enter_load: busy=%b rdy=%b en=%b (want 1 1 0000)", busy, in_ready, en);
        end
        in_valid = 1'b1;
        for (int i = 0; i < NR; i++) begin
            in_data = w[i];
            cs = cs ^ w[i];
            tick();
            checks++;
            if (en !== NR'(1 << i) || val !== w[i] || done !== (i == NR - 1 && !CK)) begin
                failures++;
                $display("FAIL basic_word%0d: en=%b val=%0d done=%b (want %b %0d %b)",
                         i, en, val, done, NR'(1 << i), w[i], (i == NR - 1 && !CK));
            end
        end
`ifdef INIT_LOADER_CHECKSUM_EN
        in_data = cs;
        tick();
        checks++;
        if (en !== '0 || done !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL basic_csum: en=%b done=%b err=%b (want 0000 1 0)", en, done, err);
        end
`endif
        in_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || en !== '0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle: busy=%b done=%b en=%b rdy=%b (want 0 0 0000 0)", busy, done, en, in_ready);
        end
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (dreg[i] !== w[i]) begin
                failures++;
                $display("FAIL basic_reg%0d: got %0d want %0d", i, dreg[i], w[i]);
            end
        end
        checks++;
        if (done_cnt - dbase !== 1) begin
            failures++;
            $display("FAIL basic_done_count: got %0d want 1", done_cnt - dbase);
        end
    endtask

    // Called straight after test_basic: start in the IDLE cycle after DONE.
    task automatic test_back_to_back();
        logic [SIZE-1:0] w [NR];
        logic [SIZE-1:0] cs;
        w = '{3'd1, 3'd3, 3'd5, 3'd6};
        cs = '0;
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 3'd4;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || en !== '0) begin
            failures++;
            $display("FAIL b2b_restart: busy=%b en=%b (want 1 0000)", busy, en);
        end
        for (int i = 0; i < NR; i++) begin
            in_data = w[i];
            cs = cs ^ w[i];
            tick();
        end
`ifdef INIT_LOADER_CHECKSUM_EN
        in_data = cs;
        tick();
`endif
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (dreg[i] !== w[i]) begin
                failures++;
                $display("FAIL b2b_reg%0d: got %0d want %0d", i, dreg[i], w[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [SIZE-1:0] w [NR];
        logic [SIZE-1:0] cs;
        int              base [NR];
        w = '{3'd3, 3'd6, 3'd0, 3'd4};
        cs = '0;
        for (int i = 0; i < NR; i++) base[i] = wr_cnt[i];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NR; i++) begin
            in_valid = 1'b1;
            in_data = w[i];
            cs = cs ^ w[i];
            tick();
            checks++;
            if (en !== NR'(1 << i) || val !== w[i]) begin
                failures++;
                $display("FAIL bp_word%0d: en=%b val=%0d (want %b %0d)", i, en, val, NR'(1 << i), w[i]);
            end
            in_valid = 1'b0;
            in_data = 3'd7;
            if (i < NR - 1) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    checks++;
                    if (en !== '0 || val !== w[i]) begin
                        failures++;
                        $display("FAIL bp_gap%0d_%0d: en=%b val=%0d (want 0000 %0d)", i, g, en, val, w[i]);
                    end
                end
            end
        end
`ifdef INIT_LOADER_CHECKSUM_EN
        in_valid = 1'b1;
        in_data = cs;
        tick();
        in_valid = 1'b0;
`endif
        tick();
        tick();
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (dreg[i] !== w[i] || wr_cnt[i] - base[i] !== 1) begin
                failures++;
                $display("FAIL bp_reg%0d: got %0d writes %0d want %0d writes 1",
                         i, dreg[i], wr_cnt[i] - base[i], w[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [SIZE-1:0] w [NR];
        logic [SIZE-1:0] cs;
        int              dbase;
        w = '{3'd2, 3'd4, 3'd6, 3'd1};
        cs = '0;
        dbase = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < NR; i++) begin
            in_data = w[i];
            cs = cs ^ w[i];
            start = (i == 2);
            tick();
            checks++;
            if (en !== NR'(1 << i) || val !== w[i]) begin
                failures++;
                $display("FAIL ign_word%0d: en=%b val=%0d (want %b %0d)", i, en, val, NR'(1 << i), w[i]);
            end
        end
        start = 1'b0;
`ifdef INIT_LOADER_CHECKSUM_EN
        in_data = cs;
        tick();
`endif
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL ign_idle%0d: busy=%b want 0", c, busy);
            end
        end
        checks++;
        if (done_cnt - dbase !== 1) begin
            failures++;
            $display("FAIL ign_done_count: got %0d want 1", done_cnt - dbase);
        end
    endtask

    task automatic test_reset_midseq();
        logic [SIZE-1:0] w [NR];
        logic [SIZE-1:0] cs;
        w = '{3'd4, 3'd3, 3'd2, 3'd6};
        cs = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 3'd5;
        tick();
        in_data = 3'd2;
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (en !== '0 || val !== '0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: en=%b val=%0d busy=%b rdy=%b done=%b (want 0000 0 0 0 0)",
                     en, val, busy, in_ready, done);
        end
        tick();
        rst = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < NR; i++) begin
            in_data = w[i];
            cs = cs ^ w[i];
            tick();
            checks++;
            if (en !== NR'(1 << i) || val !== w[i]) begin
                failures++;
                $display("FAIL rst_reload%0d: en=%b val=%0d (want %b %0d)", i, en, val, NR'(1 << i), w[i]);
            end
        end
`ifdef INIT_LOADER_CHECKSUM_EN
        in_data = cs;
        tick();
`endif
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (dreg[i] !== w[i] || wr_cnt[i] !== 1) begin
                failures++;
                $display("FAIL rst_reg%0d: got %0d writes %0d want %0d writes 1", i, dreg[i], wr_cnt[i], w[i]);
            end
        end
    endtask

`ifdef INIT_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [SIZE-1:0] w [NR];
        logic [SIZE-1:0] ckw [2];
        logic            want [2];
        w = '{3'd5, 3'd2, 3'd7, 3'd1};
        ckw = '{3'd1, 3'd6};
        want = '{1'b0, 1'b1};
        for (int r = 0; r < 2; r++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            checks++;
            if (err !== 1'b0) begin
                failures++;
                $display("FAIL csum_clear%0d: err=%b want 0", r, err);
            end
            in_valid = 1'b1;
            for (int i = 0; i < NR; i++) begin
                in_data = w[i];
                tick();
            end
            checks++;
            if (done !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL csum_check_state%0d: done=%b rdy=%b (want 0 1)", r, done, in_ready);
            end
            in_data = ckw[r];
            tick();
            in_valid = 1'b0;
            checks++;
            if (err !== want[r] || en !== '0 || done !== 1'b1 || val !== 3'd1) begin
                failures++;
                $display("FAIL csum_result%0d: err=%b en=%b done=%b val=%0d (want %b 0000 1 1)",
                         r, err, en, done, val, want[r]);
            end
            repeat (3) tick();
            checks++;
            if (err !== want[r]) begin
                failures++;
                $display("FAIL csum_hold%0d: err=%b want %b", r, err, want[r]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_start_ignored();
`ifdef INIT_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_midseq();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL final_err: err=%b want 0", err);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
